// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared constants for the decode stage (forward selects, instruction fields)
package decode_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   localparam int OP_MSB    = 31;
   localparam int OP_LSB    = 26;
   localparam int FUNCT_MSB = 5;
   localparam int FUNCT_LSB = 0;
   localparam int RS_LSB    = 21;
   localparam int RT_LSB    = 16;
   localparam int RD_LSB    = 11;
   localparam int JADDR_W   = 26;

endpackage

// File: rtl/decode_stage_param_if.sv
// rtl/decode_stage_param_if.sv - ID/EX pipeline bundle with its stall/flush controls
interface decode_stage_param_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
);
   logic              StallE;
   logic              FlushE;
   logic [DATA_W-1:0] RD1E;
   logic [DATA_W-1:0] RD2E;
   logic [REG_AW-1:0] RsE;
   logic [REG_AW-1:0] RtE;
   logic [REG_AW-1:0] RdE;
   logic [DATA_W-1:0] ImmE;

   modport master (input StallE, FlushE, output RD1E, RD2E, RsE, RtE, RdE, ImmE);
   modport slave  (output StallE, FlushE, input RD1E, RD2E, RsE, RtE, RdE, ImmE);
endinterface

// File: rtl/decode_stage_param_regfile_bypass.sv
// rtl/decode_stage_param_regfile_bypass.sv - two-read one-write register file, zero register, write-to-read bypass
module regfile_bypass #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [REG_AW-1:0] raddr_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic [REG_AW-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_b
);
   localparam int NREG = 2 ** REG_AW;

   logic [DATA_W-1:0] mem [NREG];
   logic              wr_live;

   // Bypass is suppressed during reset so every register reads 0 while rst_n is low.
   assign wr_live = we && rst_n && (waddr != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) mem[i] <= '0;
      end else if (wr_live) begin
         mem[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata_a = mem[raddr_a];
      if (raddr_a == '0)                      rdata_a = '0;
      else if (wr_live && waddr == raddr_a)   rdata_a = wdata;
   end

   always_comb begin
      rdata_b = mem[raddr_b];
      if (raddr_b == '0)                      rdata_b = '0;
      else if (wr_live && waddr == raddr_b)   rdata_b = wdata;
   end
endmodule

// File: rtl/decode_stage_param.sv
// rtl/decode_stage_param.sv - MIPS decode stage with forwarding, branch resolve and ID/EX register; option DECODE_JR_EN
module decode_stage_param
   import decode_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int IMM_W  = 16
) (
   input  logic              clkD,
   input  logic              rstD,
   input  logic [31:0]       instrD,
   input  logic [DATA_W-1:0] PCPlus4D,
   input  logic [1:0]        ForwardAD,
   input  logic [1:0]        ForwardBD,
   input  logic [DATA_W-1:0] AluOutM_D,
   input  logic [DATA_W-1:0] ResultW,
   input  logic [REG_AW-1:0] WriteRegW,
   input  logic              RegWriteW,
   input  logic              ExtOpD,
   input  logic              BranchD,
   input  logic              BneD,
   output logic [5:0]        OPCode,
   output logic [5:0]        Funct,
   output logic              EqualD,
   output logic              PCSrcD,
   output logic [DATA_W-1:0] PCBranchD,
   output logic [DATA_W-1:0] PCJumpD,
`ifdef DECODE_JR_EN
   input  logic              JrD,
   output logic [DATA_W-1:0] PCJrD,
`endif
   decode_stage_param_if.master idex
);
   logic [REG_AW-1:0] rs_d, rt_d, rd_d;
   logic [IMM_W-1:0]  imm_f;
   logic [DATA_W-1:0] rf_a, rf_b, out1, out2;
   logic [DATA_W-1:0] imm_sext, imm_zext, imm_d;
   logic              branch_hit;

   assign OPCode = instrD[OP_MSB:OP_LSB];
   assign Funct  = instrD[FUNCT_MSB:FUNCT_LSB];
   assign rs_d   = instrD[RS_LSB +: REG_AW];
   assign rt_d   = instrD[RT_LSB +: REG_AW];
   assign rd_d   = instrD[RD_LSB +: REG_AW];
   assign imm_f  = instrD[IMM_W-1:0];

   regfile_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rf (
      .clk     (clkD),
      .rst_n   (rstD),
      .we      (RegWriteW),
      .waddr   (WriteRegW),
      .wdata   (ResultW),
      .raddr_a (rs_d),
      .rdata_a (rf_a),
      .raddr_b (rt_d),
      .rdata_b (rf_b)
   );

   // Reserved select 2'b11 falls through to the register file value.
   always_comb begin
      out1 = rf_a;
      case (ForwardAD)
         FWD_RF:  out1 = rf_a;
         FWD_MEM: out1 = AluOutM_D;
         FWD_WB:  out1 = ResultW;
         default: out1 = rf_a;
      endcase
   end

   always_comb begin
      out2 = rf_b;
      case (ForwardBD)
         FWD_RF:  out2 = rf_b;
         FWD_MEM: out2 = AluOutM_D;
         FWD_WB:  out2 = ResultW;
         default: out2 = rf_b;
      endcase
   end

   assign imm_sext = {{(DATA_W-IMM_W){imm_f[IMM_W-1]}}, imm_f};
   assign imm_zext = {{(DATA_W-IMM_W){1'b0}}, imm_f};
   assign imm_d    = ExtOpD ? imm_zext : imm_sext;

   // Branch offset is always signed, independent of ExtOpD.
   assign PCBranchD = PCPlus4D + (imm_sext << 2);

   always_comb begin
      PCJumpD = PCPlus4D;
      PCJumpD[JADDR_W+1:0] = {instrD[JADDR_W-1:0], 2'b00};
   end

   assign EqualD     = (out1 == out2);
   assign branch_hit = BranchD & (EqualD ^ BneD);

`ifdef DECODE_JR_EN
   assign PCJrD  = out1;
   assign PCSrcD = branch_hit & ~JrD;
`else
   assign PCSrcD = branch_hit;
`endif

   always_ff @(posedge clkD or negedge rstD) begin
      if (!rstD || idex.FlushE) begin
         idex.RD1E <= '0;
         idex.RD2E <= '0;
         idex.RsE  <= '0;
         idex.RtE  <= '0;
         idex.RdE  <= '0;
         idex.ImmE <= '0;
      end else if (!idex.StallE) begin
         idex.RD1E <= out1;
         idex.RD2E <= out2;
         idex.RsE  <= rs_d;
         idex.RtE  <= rt_d;
         idex.RdE  <= rd_d;
         idex.ImmE <= imm_d;
      end
   end
endmodule

// File: tb/tb_decode_stage_param.sv
// tb/tb_decode_stage_param.sv - directed vector bench for decode_stage_param
module tb_decode_stage_param;
   logic        clkD = 1'b0;
   logic        rstD;
   logic [31:0] instrD, PCPlus4D, AluOutM_D, ResultW;
   logic [1:0]  ForwardAD, ForwardBD;
   logic [4:0]  WriteRegW;
   logic        RegWriteW, ExtOpD, BranchD, BneD;
   logic [5:0]  OPCode, Funct;
   logic        EqualD, PCSrcD;
   logic [31:0] PCBranchD, PCJumpD;
`ifdef DECODE_JR_EN
   logic        JrD;
   logic [31:0] PCJrD;
`endif

   int errors = 0;
   int checks = 0;

   decode_stage_param_if #(.DATA_W(32), .REG_AW(5)) idex ();

   decode_stage_param #(.DATA_W(32), .REG_AW(5), .IMM_W(16)) dut (
      .clkD(clkD), .rstD(rstD), .instrD(instrD), .PCPlus4D(PCPlus4D),
      .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .AluOutM_D(AluOutM_D),
      .ResultW(ResultW), .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
      .ExtOpD(ExtOpD), .BranchD(BranchD), .BneD(BneD), .OPCode(OPCode),
      .Funct(Funct), .EqualD(EqualD), .PCSrcD(PCSrcD), .PCBranchD(PCBranchD),
      .PCJumpD(PCJumpD),
`ifdef DECODE_JR_EN
      .JrD(JrD), .PCJrD(PCJrD),
`endif
      .idex(idex)
   );

   always #5 clkD = ~clkD;

   typedef struct {
      logic [31:0] instr, pc, alu, res;
      logic [1:0]  fa, fb;
      logic        ext, br, bne;
      logic [5:0]  op, fn;
      logic        eq, src;
      logic [31:0] pcb, pcj, rd1, rd2, imm;
      logic [4:0]  rs, rt, rd;
   } vec_t;

   vec_t v [4];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clkD);
      #1;
   endtask

   task automatic drive(input vec_t t);
      instrD = t.instr; PCPlus4D = t.pc; AluOutM_D = t.alu; ResultW = t.res;
      ForwardAD = t.fa; ForwardBD = t.fb; ExtOpD = t.ext; BranchD = t.br; BneD = t.bne;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      ForwardAD = 2'b00; ForwardBD = 2'b00;
      RegWriteW = 1'b1; WriteRegW = a; ResultW = d;
      tick();
      RegWriteW = 1'b0;
   endtask

   task automatic chk_e_zero(input string nm);
      chk({nm, "_rd1e"}, idex.RD1E, 32'h0);
      chk({nm, "_rd2e"}, idex.RD2E, 32'h0);
      chk({nm, "_rse"},  {27'h0, idex.RsE}, 32'h0);
      chk({nm, "_rte"},  {27'h0, idex.RtE}, 32'h0);
      chk({nm, "_rde"},  {27'h0, idex.RdE}, 32'h0);
      chk({nm, "_imme"}, idex.ImmE, 32'h0);
   endtask

   initial begin
      v[0] = '{32'h10220010, 32'h00000100, 32'h00000011, 32'h00000011, 2'b01, 2'b10, 1'b0, 1'b1, 1'b0,
               6'h04, 6'h10, 1'b1, 1'b1, 32'h00000140, 32'h00880040, 32'h00000011, 32'h00000011,
               32'h00000010, 5'd1, 5'd2, 5'd0};
      v[1] = '{32'h14A58004, 32'h00000100, 32'hA5A5A5A5, 32'h5A5A5A5A, 2'b01, 2'b10, 1'b1, 1'b1, 1'b1,
               6'h05, 6'h04, 1'b0, 1'b1, 32'hFFFE0110, 32'h02960010, 32'hA5A5A5A5, 32'h5A5A5A5A,
               32'h00008004, 5'd5, 5'd5, 5'd16};
      v[2] = '{32'h14A58004, 32'hF0000000, 32'hA5A5A5A5, 32'h5A5A5A5A, 2'b01, 2'b10, 1'b0, 1'b1, 1'b0,
               6'h05, 6'h04, 1'b0, 1'b0, 32'hEFFE0010, 32'hF2960010, 32'hA5A5A5A5, 32'h5A5A5A5A,
               32'hFFFF8004, 5'd5, 5'd5, 5'd16};
      v[3] = '{32'h00642820, 32'h00000004, 32'hDEAD0000, 32'hBEEF0000, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0,
               6'h00, 6'h20, 1'b1, 1'b0, 32'h0000A084, 32'h0190A080, 32'h00000000, 32'h00000000,
               32'h00002820, 5'd3, 5'd4, 5'd5};

      rstD = 1'b0; instrD = '0; PCPlus4D = '0; AluOutM_D = '0; ResultW = '0;
      ForwardAD = '0; ForwardBD = '0; WriteRegW = '0; RegWriteW = 1'b0;
      ExtOpD = 1'b0; BranchD = 1'b0; BneD = 1'b0;
      idex.StallE = 1'b0; idex.FlushE = 1'b0;
`ifdef DECODE_JR_EN
      JrD = 1'b0;
`endif
      tick(); tick();
      chk_e_zero("reset");
      rstD = 1'b1;

      for (int i = 0; i < 4; i++) begin
         drive(v[i]);
         #1;
         chk($sformatf("v%0d_op", i),  {26'h0, OPCode}, {26'h0, v[i].op});
         chk($sformatf("v%0d_fn", i),  {26'h0, Funct},  {26'h0, v[i].fn});
         chk($sformatf("v%0d_eq", i),  {31'h0, EqualD}, {31'h0, v[i].eq});
         chk($sformatf("v%0d_src", i), {31'h0, PCSrcD}, {31'h0, v[i].src});
         chk($sformatf("v%0d_pcb", i), PCBranchD, v[i].pcb);
         chk($sformatf("v%0d_pcj", i), PCJumpD,   v[i].pcj);
         tick();
         chk($sformatf("v%0d_rd1e", i), idex.RD1E, v[i].rd1);
         chk($sformatf("v%0d_rd2e", i), idex.RD2E, v[i].rd2);
         chk($sformatf("v%0d_imme", i), idex.ImmE, v[i].imm);
         chk($sformatf("v%0d_rse", i), {27'h0, idex.RsE}, {27'h0, v[i].rs});
         chk($sformatf("v%0d_rte", i), {27'h0, idex.RtE}, {27'h0, v[i].rt});
         chk($sformatf("v%0d_rde", i), {27'h0, idex.RdE}, {27'h0, v[i].rd});
      end

      // same-cycle write bypass, then stored value, then r0 stays zero
      BranchD = 1'b0; BneD = 1'b0; ExtOpD = 1'b0;
      instrD = 32'h00A00000;
      wr(5'd5, 32'h00001234);
      chk("bypass_rd1e", idex.RD1E, 32'h00001234);
      tick();
      chk("stored_rd1e", idex.RD1E, 32'h00001234);
      instrD = 32'h00000000;
      wr(5'd0, 32'hFFFFFFFF);
      chk("r0_wr_rd1e", idex.RD1E, 32'h0);
      tick();
      chk("r0_rd1e", idex.RD1E, 32'h0);

      // BEQ / BNE resolution from register values
      wr(5'd1, 32'd7);
      wr(5'd2, 32'd7);
      instrD = 32'h10220000; BranchD = 1'b1; BneD = 1'b0;
      #1;
      chk("beq_eq",  {31'h0, EqualD}, 32'h1);
      chk("beq_src", {31'h0, PCSrcD}, 32'h1);
      BneD = 1'b1;
      #1;
      chk("bne_eq_src", {31'h0, PCSrcD}, 32'h0);
      wr(5'd2, 32'd8);
      #1;
      chk("bne_ne_eq",  {31'h0, EqualD}, 32'h0);
      chk("bne_ne_src", {31'h0, PCSrcD}, 32'h1);

      // stall holds, flush beats stall
      drive(v[1]);
      tick();
      idex.StallE = 1'b1;
      drive(v[3]);
      for (int c = 0; c < 2; c++) begin
         tick();
         chk($sformatf("stall%0d_rd1e", c), idex.RD1E, 32'hA5A5A5A5);
         chk($sformatf("stall%0d_rd2e", c), idex.RD2E, 32'h5A5A5A5A);
         chk($sformatf("stall%0d_rde", c), {27'h0, idex.RdE}, 32'd16);
         chk($sformatf("stall%0d_imme", c), idex.ImmE, 32'h00008004);
      end
      idex.FlushE = 1'b1;
      tick();
      chk_e_zero("flush");
      idex.StallE = 1'b0; idex.FlushE = 1'b0;

      // asynchronous reset mid-cycle
      drive(v[1]);
      tick();
      chk("pre_rst_rd1e", idex.RD1E, 32'hA5A5A5A5);
      #2;
      rstD = 1'b0;
      #1;
      chk_e_zero("async_rst");
      instrD = 32'h10220000; ForwardAD = 2'b00; ForwardBD = 2'b00; BranchD = 1'b1; BneD = 1'b0;
      #1;
      chk("rst_regs_eq", {31'h0, EqualD}, 32'h1);
      @(negedge clkD);
      rstD = 1'b1;
      instrD = 32'h00A00000; BranchD = 1'b0;
      tick();
      chk("rst_r5_lost", idex.RD1E, 32'h0);

`ifdef DECODE_JR_EN
      wr(5'd31, 32'h00400020);
      instrD = 32'h13FF0000; BranchD = 1'b1; BneD = 1'b0; JrD = 1'b1;
      #1;
      chk("jr_target", PCJrD, 32'h00400020);
      chk("jr_src",    {31'h0, PCSrcD}, 32'h0);
      JrD = 1'b0;
      #1;
      chk("jr_off_src", {31'h0, PCSrcD}, 32'h1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
